// File: rtl/uart_program_loader_pkg.sv
// Shared types and UART frame constants for the program loader.
package common;

  // UART frame shape: 8N1
  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  // Loader: collect word count, then stream words, then release the cpu
  typedef enum logic [1:0] {
    LD_LEN,
    LD_WORDS,
    LD_DONE
  } loader_state_e;

  // Receiver bit-level states
  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

endpackage

// File: rtl/uart_rx.sv
// UART 8N1 receiver: input synchronizer, mid-bit sampling FSM,
// one-cycle byte_valid strobe and a sticky framing-error flag.
module uart_rx
  import common::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rx,
  output logic                 byte_valid,
  output logic [DATA_BITS-1:0] byte_data,
  output logic                 frame_err
);

  localparam int CW    = $clog2(CLKS_PER_BIT + 1);
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [CW-1:0]    FULL_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]    HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

  logic                 meta_q, meta_d;
  logic                 sync_q, sync_d;
  logic                 prev_q, prev_d;
  rx_state_e            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;

  // State registers; synchronizer chain resets to the idle (high) level
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q  <= 1'b1;
      sync_q  <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      meta_q  <= meta_d;
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  // Bit FSM: detect start edge, confirm at half-bit, then sample every full bit
  always_comb begin
    meta_d  = rx;
    sync_d  = meta_q;
    prev_d  = sync_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = ferr_q;
    case (state_q)
      RX_IDLE: begin
        if (prev_q && !sync_q) begin
          state_d = RX_START;
          cnt_d   = '0;
        end
      end
      RX_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          if (sync_q) begin
            state_d = RX_IDLE;   // too short to be a start bit
          end else begin
            state_d = RX_DATA;
            bit_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {sync_q, shift_q[DATA_BITS-1:1]};
          if (bit_q == LAST_BIT) state_d = RX_STOP;
          else                   bit_d   = bit_q + BIT_W'(1);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          if (sync_q) valid_d = 1'b1;
          else        ferr_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign byte_valid = valid_q;
  assign byte_data  = shift_q;
  assign frame_err  = ferr_q;

endmodule

// File: rtl/uart_program_loader.sv
// Receives a length-prefixed little-endian program image over UART,
// writes it to program memory, then releases the cpu from reset.
module uart_program_loader
  import common::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int MEM_WORDS    = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        io_rx,
  output logic        mem_write_enable,
  output logic [31:0] mem_byte_address,
  output logic [31:0] mem_write_data,
  output logic        cpu_reset_n,
  output logic        load_done,
  output logic        frame_error
);

  logic                 byte_valid;
  logic [DATA_BITS-1:0] byte_data;
  logic                 rx_frame_err;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk        (clk),
    .reset_n    (reset_n),
    .rx         (io_rx),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_err  (rx_frame_err)
  );

  loader_state_e state_q, state_d;
  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic [31:0]   asm_q, asm_d;
  logic [31:0]   n_q, n_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wcnt_q, wcnt_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          we_q, we_d;
  logic          word_done_q, word_done_d;
  logic          done_q, done_d;
  logic [31:0]   asm_next;

  // Each new byte lands in the top byte; after four shifts the first is at bits 7:0
  assign asm_next = {byte_data, asm_q[31:8]};

  // Loader registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= LD_LEN;
      byte_cnt_q  <= '0;
      asm_q       <= '0;
      n_q         <= '0;
      addr_q      <= '0;
      wcnt_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      word_done_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      asm_q       <= asm_d;
      n_q         <= n_d;
      addr_q      <= addr_d;
      wcnt_q      <= wcnt_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      word_done_q <= word_done_d;
      done_q      <= done_d;
    end
  end

  // Loader FSM: length header, word stream with write strobes, then done
  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    asm_d       = asm_q;
    n_d         = n_q;
    addr_d      = addr_q;
    wcnt_d      = wcnt_q;
    wdata_d     = wdata_q;
    we_d        = 1'b0;
    word_done_d = 1'b0;
    case (state_q)
      LD_LEN: begin
        if (byte_valid) begin
          asm_d      = asm_next;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            n_d     = asm_next;
            addr_d  = '0;
            wcnt_d  = '0;
            state_d = (asm_next == 32'd0) ? LD_DONE : LD_WORDS;
          end
        end
      end
      LD_WORDS: begin
        // Advance address/count in the cycle the write is presented
        if (word_done_q) begin
          addr_d = addr_q + 32'd4;
          wcnt_d = wcnt_q + 32'd1;
          if (wcnt_q + 32'd1 == n_q) state_d = LD_DONE;
        end
        if (byte_valid) begin
          asm_d      = asm_next;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            word_done_d = 1'b1;
            // Words beyond memory capacity are counted but never written
            if (wcnt_q < 32'(MEM_WORDS)) begin
              we_d    = 1'b1;
              wdata_d = asm_next;
            end
          end
        end
      end
      default: ;  // LD_DONE: ignore everything until reset
    endcase
    if (state_d != state_q) byte_cnt_d = '0;
    done_d = (state_d == LD_DONE);
  end

  assign mem_write_enable = we_q;
  assign mem_byte_address = addr_q;
  assign mem_write_data   = wdata_q;
  assign cpu_reset_n      = done_q;
  assign load_done        = done_q;
  assign frame_error      = rx_frame_err;

endmodule

// File: tb/tb_uart_program_loader.sv
// Directed bench for uart_program_loader with a write scoreboard.
module tb_uart_program_loader;
  import common::*;

  localparam int CPB = 4;
  localparam int MW  = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        io_rx = 1'b1;
  logic        mem_write_enable;
  logic [31:0] mem_byte_address;
  logic [31:0] mem_write_data;
  logic        cpu_reset_n;
  logic        load_done;
  logic        frame_error;

  always #5 clk = ~clk;

  uart_program_loader #(.CLKS_PER_BIT(CPB), .MEM_WORDS(MW)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .io_rx            (io_rx),
    .mem_write_enable (mem_write_enable),
    .mem_byte_address (mem_byte_address),
    .mem_write_data   (mem_write_data),
    .cpu_reset_n      (cpu_reset_n),
    .load_done        (load_done),
    .frame_error      (frame_error)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  // Cycle counter and output monitor (single writer for each variable)
  int          cyc = 0;
  logic [31:0] obs_addr [256];
  logic [31:0] obs_data [256];
  int          obs_cyc  [256];
  int          obs_n = 0;
  int          bv_n = 0;
  int          last_bv_cyc = -1;
  int          done_rise_cyc = -1;
  logic        done_prev = 1'b0;
  int          rd_ptr = 0;

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (mem_write_enable) begin
      obs_addr[obs_n % 256] = mem_byte_address;
      obs_data[obs_n % 256] = mem_write_data;
      obs_cyc[obs_n % 256]  = cyc;
      obs_n = obs_n + 1;
    end
    if (dut.u_rx.byte_valid) begin
      bv_n = bv_n + 1;
      last_bv_cyc = cyc;
    end
    if (load_done && !done_prev) done_rise_cyc = cyc;
    done_prev = load_done;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    io_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      io_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    io_rx = stop_bit;
    repeat (CPB) @(negedge clk);
    io_rx = 1'b1;
    repeat (2) @(negedge clk);
    $display("tx byte %h stop=%0b", b, stop_bit);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
  endtask

  task automatic expect_write(input logic [31:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Compare every write seen since the last drain against the scoreboard
  task automatic drain_writes(input string tag);
    wr_t e;
    while (rd_ptr < obs_n) begin
      if (exp_q.size() == 0) begin
        check({tag, " unexpected write addr"}, obs_addr[rd_ptr % 256], 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check({tag, " write addr"}, obs_addr[rd_ptr % 256], e.addr);
        check({tag, " write data"}, obs_data[rd_ptr % 256], e.data);
        $display("write addr=%h data=%h", obs_addr[rd_ptr % 256], obs_data[rd_ptr % 256]);
      end
      rd_ptr++;
    end
    check({tag, " missing writes"}, 32'(exp_q.size()), 32'd0);
  endtask

  // Assert reset off the clock edge and confirm outputs clear immediately
  task automatic do_reset(input string tag);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    io_rx   = 1'b1;
    #1;
    check({tag, " rst we"},    32'(mem_write_enable), 32'd0);
    check({tag, " rst addr"},  mem_byte_address,      32'd0);
    check({tag, " rst data"},  mem_write_data,        32'd0);
    check({tag, " rst cpu_n"}, 32'(cpu_reset_n),      32'd0);
    check({tag, " rst done"},  32'(load_done),        32'd0);
    check({tag, " rst ferr"},  32'(frame_error),      32'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rd_ptr  = obs_n;
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (load_done) break;
    end
    check({tag, " load_done"}, 32'(load_done), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    int w0, b0;
    // Power-on reset
    do_reset("por");

    // Two-word image
    expect_write(32'h0, 32'h0010_0513);
    expect_write(32'h4, 32'h0020_0593);
    send_word(32'd2);
    send_word(32'h0010_0513);
    send_word(32'h0020_0593);
    wait_done("img2");
    drain_writes("img2");
    check("img2 done timing", 32'(done_rise_cyc), 32'(obs_cyc[(obs_n - 1) % 256] + 1));
    check("img2 cpu_reset_n", 32'(cpu_reset_n), 32'd1);

    // Empty image
    do_reset("n0");
    w0 = obs_n;
    send_word(32'd0);
    wait_done("n0");
    drain_writes("n0");
    check("n0 write count", 32'(obs_n - w0), 32'd0);
    check("n0 done timing", 32'(done_rise_cyc), 32'(last_bv_cyc + 1));

    // Image larger than memory
    do_reset("ovf");
    w0 = obs_n;
    send_word(32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < MW) expect_write(32'(4 * i), 32'hA000_0000 + 32'(i));
      send_word(32'hA000_0000 + 32'(i));
    end
    wait_done("ovf");
    drain_writes("ovf");
    check("ovf write count", 32'(obs_n - w0), 32'd4);
    check("ovf words counted", dut.wcnt_q, 32'd5);

    // Bytes after done are ignored
    w0 = obs_n;
    send_word(32'hDEAD_BEEF);
    repeat (10) @(negedge clk);
    drain_writes("post");
    check("post write count", 32'(obs_n - w0), 32'd0);
    check("post load_done", 32'(load_done), 32'd1);

    // Glitch and framing error
    do_reset("ferr");
    b0 = bv_n;
    @(negedge clk);
    io_rx = 1'b0;
    @(negedge clk);
    io_rx = 1'b1;
    repeat (20) @(negedge clk);
    send_byte(8'hA5, 1'b0);
    repeat (10) @(negedge clk);
    check("ferr byte_valid count", 32'(bv_n - b0), 32'd0);
    check("ferr frame_error", 32'(frame_error), 32'd1);
    check("ferr loader state", 32'(dut.state_q), 32'(LD_LEN));
    repeat (50) @(negedge clk);
    check("ferr sticky", 32'(frame_error), 32'd1);
    check("ferr load_done", 32'(load_done), 32'd0);

    // Reset mid-load, then a full reload
    do_reset("abort");
    expect_write(32'h0, 32'h1111_0001);
    expect_write(32'h4, 32'h2222_0002);
    send_word(32'd3);
    send_word(32'h1111_0001);
    send_word(32'h2222_0002);
    repeat (10) @(negedge clk);
    drain_writes("abort partial");
    do_reset("abort");
    expect_write(32'h0, 32'h1111_0001);
    expect_write(32'h4, 32'h2222_0002);
    expect_write(32'h8, 32'h3333_0003);
    send_word(32'd3);
    send_word(32'h1111_0001);
    send_word(32'h2222_0002);
    send_word(32'h3333_0003);
    wait_done("reload");
    drain_writes("reload");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_program_loader.md
UART_PROGRAM_LOADER -- requirements
Module: uart_program_loader

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, meaning clk cycles per UART bit (100 MHz / 115200 baud).
REQ-002 Parameter MEM_WORDS, default 1024, meaning program memory capacity in 32-bit words.
REQ-003 Port clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 Port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 Port io_rx  input  1  UART serial line, idle high, 8N1, LSB first, asynchronous to clk.
REQ-006 Port mem_write_enable  output  1  one-cycle write strobe to program memory.
REQ-007 Port mem_byte_address  output  32  word-aligned byte address of the current write.
REQ-008 Port mem_write_data  output  32  word to write, valid when mem_write_enable is high.
REQ-009 Port cpu_reset_n  output  1  active-low reset for the cpu; low until loading completes.
REQ-010 Port load_done  output  1  high once all words are loaded; stays high until reset.
REQ-011 Port frame_error  output  1  sticky flag; set when any byte has a stop bit of 0.

Function
REQ-012 io_rx SHALL pass through a 2-flop synchronizer (reset value 1) before any use.
REQ-013 Receiver states: IDLE, START, DATA, STOP; a falling edge in IDLE enters START.
REQ-014 START samples at CLKS_PER_BIT/2; a high sample is a glitch and returns to IDLE; a low sample enters DATA.
REQ-015 DATA samples each of 8 bits at CLKS_PER_BIT intervals from the start-bit midpoint; STOP samples one further interval later.
REQ-016 byte_valid SHALL pulse for one cycle, the cycle after the stop-bit sample, only if the stop bit is 1; if it is 0, the byte is dropped and frame_error is set.
REQ-017 Loader states: LEN, WORDS, DONE; reset enters LEN.
REQ-018 LEN collects 4 bytes into word count N, little-endian (first byte = bits 7:0).
REQ-019 After the 4th LEN byte: N=0 goes directly to DONE; otherwise go to WORDS with address 0 and word count 0.
REQ-020 WORDS assembles every 4 bytes little-endian; mem_write_enable pulses the cycle after the 4th byte's byte_valid, with the completed data and current address.
REQ-021 After each write, address += 4 (32-bit wrap) and word count += 1; on word count == N, the next state is DONE.
REQ-022 Words with index >= MEM_WORDS SHALL be received and counted but not written (mem_write_enable held low).
REQ-023 DONE: load_done=1 and cpu_reset_n=1 from the cycle DONE is entered; receiver keeps running; bytes are ignored; no further writes.
REQ-024 Byte assembly count SHALL reset on each state change, so no partial byte is carried across the LEN-to-WORDS transition.
REQ-025 mem_write_enable is low in all cycles other than those named in REQ-020.

Reset
REQ-026 While reset_n=0, all outputs SHALL be: mem_write_enable=0, mem_byte_address=0, mem_write_data=0, cpu_reset_n=0, load_done=0, frame_error=0.
REQ-027 Reset asserted mid-byte or mid-load SHALL abort immediately; the load restarts from LEN; memory contents already written are not cleared.
REQ-028 cpu_reset_n SHALL be driven from a register, never combinationally from reset_n.

Structure
REQ-029 The loader state enum and the UART frame constants (8 data bits, 1 stop bit) SHALL live in package common.
REQ-030 The receiver SHALL be sub-module uart_rx (synchronizer, bit FSM, byte_valid/byte_data/frame_err outputs); the loader FSM and word assembly stay in the top module.
REQ-031 The cpu top-level SHALL connect io_rx, the program memory write port and the cpu reset to this block.

Verification (CLKS_PER_BIT=4, MEM_WORDS=4)
REQ-032 Send 02 00 00 00, 13 05 10 00, 93 05 20 00 -> writes (0x0,0x00100513), (0x4,0x00200593); load_done and cpu_reset_n rise in the cycle after the 2nd write.
REQ-033 Send 00 00 00 00 -> no writes; load_done=1 one cycle after the 4th byte_valid.
REQ-034 Send N=5 plus 5 words -> exactly 4 writes (0x0-0xC); 5th word counted but not written; load_done=1.
REQ-035 Send a 1-cycle low glitch on io_rx, then a byte with stop bit 0 -> no byte_valid for either; frame_error=1 and stays 1; loader remains in LEN.
REQ-036 Assert reset_n=0 after 2 of 3 words, then resend full image -> all outputs at reset values during reset; writes restart at address 0x0.
REQ-037 Send bytes after DONE -> mem_write_enable stays 0; load_done stays 1.
